regfile_dumper: RTL
===================

REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 The block SHALL have parameter FIRST_REG, default 0, meaning the index of the first register dumped.
REQ-002 The block SHALL have parameter LAST_REG, default 31, meaning the index of the last register dumped; legal when FIRST_REG <= LAST_REG <= 31.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, positive edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: dump request, sampled in IDLE only.
REQ-006 The block SHALL have port abort, input, 1 bit: cancels an active dump.
REQ-007 The block SHALL have port rf_raddr, output, 5 bits: read index driven to a spare asynchronous register-file read port.
REQ-008 The block SHALL have port rf_rdata, input, 32 bits: combinational read data for rf_raddr.
REQ-009 The block SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit), out_data (output, 32 bits), out_index (output, 5 bits) and out_last (output, 1 bit), forming the stream output.
REQ-010 The block SHALL have ports busy (output, 1 bit), high outside IDLE, and done (output, 1 bit), a one-cycle completion pulse.

Function
REQ-011 The FSM SHALL use states IDLE and SEND, plus CSUM when the checksum option is compiled in.
REQ-012 In IDLE, rf_raddr SHALL equal FIRST_REG; in SEND, rf_raddr SHALL equal out_index+1, saturating at LAST_REG.
REQ-013 In IDLE, start=1 SHALL load out_data<=rf_rdata and out_index<=FIRST_REG, set out_valid on the next cycle, and move the FSM to SEND.
REQ-014 A beat SHALL complete on the rising edge where out_valid&&out_ready; while out_ready=0, out_data, out_index and out_last SHALL hold stable.
REQ-015 On a completed non-final beat, out_data SHALL reload from rf_rdata and out_index SHALL increment, sustaining one beat per cycle when out_ready stays high.
REQ-016 Captured data SHALL stay frozen in the output register; register-file writes after capture SHALL NOT alter a pending beat.
REQ-017 A dump SHALL be exactly LAST_REG-FIRST_REG+1 data beats; with FIRST_REG=LAST_REG, out_last SHALL assert on the first beat.
REQ-018 The final beat SHALL assert out_last. Its completion SHALL clear out_valid and return to IDLE, and done SHALL pulse in the following cycle.
REQ-019 start while busy SHALL be ignored; start in the same cycle as done's IDLE return SHALL begin a new dump.
REQ-020 abort in SEND or CSUM SHALL, on the next edge, clear out_valid, return to IDLE and suppress done; abort SHALL take priority over a simultaneous handshake.
REQ-021 Index 0 SHALL be dumped as whatever rf_rdata returns, with no special casing in this block.

Reset
REQ-022 While rst_n=0 at a clock edge, the FSM SHALL enter IDLE with out_valid=0, out_last=0, busy=0, done=0, out_data=0, out_index=0, and any running checksum=0.
REQ-023 Reset mid-dump SHALL discard the dump without generating done.

Configuration
REQ-024 Macro RF_DUMP_CHECKSUM_EN SHALL be the single compile-time option.
REQ-025 With RF_DUMP_CHECKSUM_EN defined, the dump SHALL append one CSUM beat after the last data beat, with out_data = XOR of all data words sent, out_index = LAST_REG and out_last=1; out_last SHALL then be low on data beats.
REQ-026 Without RF_DUMP_CHECKSUM_EN, there SHALL be no CSUM state, no checksum register and no extra beat.

Structure
REQ-027 XLEN=32, REG_ADDR_W=5 and the FSM state enum SHALL live in shared package rv32_pkg.
REQ-028 The block SHALL be a single module with no sub-module; rf_raddr SHALL be the only combinational output.

Verification
REQ-029 Full dump: preload x1..x31 = 0x1000+i, x0 = 0, start, out_ready=1 -> 32 consecutive beats with index 0..31, data 0, 0x1001..0x101F, out_last on index 31, and done one cycle after.
REQ-030 Backpressure: toggle out_ready 0/1 randomly -> beats in order, data and index stable while stalled, no loss or duplication.
REQ-031 Abort: assert abort at beat index 10 while out_ready=1 -> out_valid low the next cycle, no done pulse, and a new start dumps from index 0.
REQ-032 Capture isolation: write x5 = 0xDEAD while beat 5 is stalled -> beat 5 carries the old value 0x1005.
REQ-033 Reset mid-dump: rst_n=0 at index 7 -> all outputs at reset values the next cycle, and start afterwards behaves per REQ-029.
REQ-034 Checksum build, FIRST_REG=1, LAST_REG=3, x1..x3 = 1, 2, 4 -> 4 beats, with the last beat data 0x7, index 3 and out_last=1.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 widths and the register-file dumper FSM state encoding.
// RF_DUMP_CHECKSUM_EN adds the CSUM state used by the optional trailing XOR beat.
package rv32_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

`ifdef RF_DUMP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CSUM = 2'd2
  } dump_state_e;
`else
  localparam bit CSUM_EN = 1'b0;
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } dump_state_e;
`endif

endpackage

// File: rtl/regfile_dumper.sv
// Streams registers FIRST_REG..LAST_REG from a spare async register-file read port.
// Define RF_DUMP_CHECKSUM_EN to append an XOR checksum beat after the data beats.
module regfile_dumper
  import rv32_pkg::*;
#(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [REG_ADDR_W-1:0] rf_raddr,
  input  logic [XLEN-1:0]       rf_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_data,
  output logic [REG_ADDR_W-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [REG_ADDR_W-1:0] FIRST_A = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_A  = REG_ADDR_W'(LAST_REG);

  dump_state_e           state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [XLEN-1:0]       out_data_q, out_data_d;
  logic [REG_ADDR_W-1:0] out_index_q, out_index_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef RF_DUMP_CHECKSUM_EN
  logic [XLEN-1:0]       csum_q, csum_d;
`endif

  logic                  beat_done;
  logic [REG_ADDR_W-1:0] next_index;

  assign beat_done  = out_valid_q && out_ready;
  assign next_index = out_index_q + REG_ADDR_W'(1);

  // Read address runs one register ahead of the pending beat so the reload is ready at handshake.
  always_comb begin
    rf_raddr = FIRST_A;
    if (state_q != ST_IDLE) begin
      rf_raddr = (out_index_q == LAST_A) ? LAST_A : next_index;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SEND;
          out_valid_d = 1'b1;
          out_data_d  = rf_rdata;
          out_index_d = FIRST_A;
          out_last_d  = !CSUM_EN && (FIRST_A == LAST_A);
`ifdef RF_DUMP_CHECKSUM_EN
          csum_d      = '0;
`endif
        end
      end

      ST_SEND: begin
        if (abort) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else if (beat_done) begin
`ifdef RF_DUMP_CHECKSUM_EN
          csum_d = csum_q ^ out_data_q;
`endif
          if (out_index_q == LAST_A) begin
`ifdef RF_DUMP_CHECKSUM_EN
            state_d    = ST_CSUM;
            out_data_d = csum_q ^ out_data_q;
            out_last_d = 1'b1;
`else
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
`endif
          end else begin
            out_data_d  = rf_rdata;
            out_index_d = next_index;
            out_last_d  = !CSUM_EN && (next_index == LAST_A);
          end
        end
      end

`ifdef RF_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (abort) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else if (beat_done) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
        end
      end
`endif

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef RF_DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
